// File: rtl/cnn_pkg.sv
// Shared constants and pixel type for the CNN feature-map pipeline stages.
// No logic: constants only, consumed at elaboration time.
// No flow control: pure package.
package cnn_pkg;

  // Activation word width leaving the batch-norm stage (signed two's complement).
  localparam int PIX_W     = 9;

  // First conv layer output map, fed into the ReLU + max-pool stage.
  localparam int FMAP_COLS = 26;
  localparam int FMAP_ROWS = 26;

  // Map size after 2x2 floor pooling; input geometry of the next layer.
  localparam int POOL_COLS = FMAP_COLS / 2;
  localparam int POOL_ROWS = FMAP_ROWS / 2;

  typedef logic signed [PIX_W-1:0] pix_t;

endpackage

// File: rtl/max2_signed.sv
// Combinational W-bit signed maximum of two operands.
// Latency: 0 cycles (pure combinational).
// No flow control: result follows the inputs.
module max2_signed #(
  parameter int W = 9
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  // Both operands are signed, so the relational compare is signed; ties pick b.
  assign y = (a > b) ? a : b;

endmodule

// File: rtl/relu_maxpool2.sv
// Streaming ReLU + non-overlapping 2x2 max-pool over a raster-order feature map.
// Latency: 1 cycle from the edge accepting a window's bottom-right pixel to dout_valid.
// No backpressure: every din_valid beat is consumed. Build option: MAXPOOL_RELU_EN enables the ReLU clamp.
module relu_maxpool2
  import cnn_pkg::*;
#(
  parameter int W    = PIX_W,
  parameter int COLS = FMAP_COLS,
  parameter int ROWS = FMAP_ROWS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [W-1:0] din,
  input  logic                din_valid,
  output logic signed [W-1:0] dout,
  output logic                dout_valid,
  output logic                frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int PC = COLS / 2;
  localparam int PR = ROWS / 2;
  localparam int IW = (PC > 1) ? $clog2(PC) : 1;

  localparam logic [CW-1:0] COL_LAST     = CW'(COLS - 1);
  localparam logic [CW-1:0] COL_PAIR_END = CW'(2 * PC - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_PAIR_END = RW'(2 * PR - 1);
  localparam bit            COLS_ODD     = (COLS % 2) == 1;
  localparam bit            ROWS_ODD     = (ROWS % 2) == 1;

  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic signed [W-1:0] h;
  logic signed [W-1:0] r;
  logic signed [W-1:0] m;
  logic signed [W-1:0] v;
  logic signed [W-1:0] lb_rd;
  logic signed [W-1:0] linebuf [PC];
  logic [IW-1:0]       lb_idx;

  logic col_odd;
  logic row_odd;
  logic col_skip;
  logic row_skip;
  logic h_load;
  logic lb_wr;
  logic out_fire;
  logic last_win;

  // Pre-stage value: clamp negatives to zero when the ReLU build option is on.
  always_comb begin
    r = din;
`ifdef MAXPOOL_RELU_EN
    if (din[W-1]) begin
      r = '0;
    end
`endif
  end

  // Position decode. The trailing column/row of an odd-sized map is a floor
  // remainder: it is counted but never joins a window.
  assign col_odd  = col[0];
  assign row_odd  = row[0];
  assign col_skip = COLS_ODD && (col == COL_LAST);
  assign row_skip = ROWS_ODD && (row == ROW_LAST);
  assign lb_idx   = IW'(col >> 1);
  assign lb_rd    = linebuf[lb_idx];

  assign h_load   = din_valid && !col_odd && !col_skip;
  assign lb_wr    = din_valid &&  col_odd && !row_odd && !row_skip;
  assign out_fire = din_valid &&  col_odd &&  row_odd;
  assign last_win = (row == ROW_PAIR_END) && (col == COL_PAIR_END);

  // Horizontal pair maximum: held left pixel against the current right pixel.
  max2_signed #(.W(W)) u_hmax (
    .a (h),
    .b (r),
    .y (m)
  );

  // Vertical maximum: upper-row pair result from the line buffer against this row's pair.
  max2_signed #(.W(W)) u_vmax (
    .a (lb_rd),
    .b (m),
    .y (v)
  );

  // Raster position counters; advance only on accepted beats, wrap at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (din_valid) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Hold the left pixel of each horizontal pair until its partner arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
    end else if (h_load) begin
      h <= r;
    end
  end

  // Half-row line buffer; every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_wr) begin
      linebuf[lb_idx] <= m;
    end
  end

  // Registered output: one-cycle strobes, dout holds its last value between windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout_valid <= out_fire;
      frame_done <= out_fire && last_win;
      if (out_fire) begin
        dout <= v;
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool2.sv
// Self-checking bench for relu_maxpool2 (4x4, 5x5 and default 26x26 instances).
// Expected results come from hard-coded vectors and a window-level reference model.
// Works in both builds: MAXPOOL_RELU_EN defined or undefined.
module tb_relu_maxpool2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic signed [8:0] din4 = '0, din5 = '0, din26 = '0;
  logic              din_valid4 = 1'b0, din_valid5 = 1'b0, din_valid26 = 1'b0;
  logic signed [8:0] dout4, dout5, dout26;
  logic              dout_valid4, dout_valid5, dout_valid26;
  logic              frame_done4, frame_done5, frame_done26;

  relu_maxpool2 #(.W(9), .COLS(4), .ROWS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din4), .din_valid(din_valid4),
    .dout(dout4), .dout_valid(dout_valid4), .frame_done(frame_done4)
  );

  relu_maxpool2 #(.W(9), .COLS(5), .ROWS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .din(din5), .din_valid(din_valid5),
    .dout(dout5), .dout_valid(dout_valid5), .frame_done(frame_done5)
  );

  relu_maxpool2 dut26 (
    .clk(clk), .rst_n(rst_n), .din(din26), .din_valid(din_valid26),
    .dout(dout26), .dout_valid(dout_valid26), .frame_done(frame_done26)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    int fd;
    int t;
  } obs_t;

  obs_t obs4[$];
  obs_t obs5[$];
  obs_t obs26[$];

  int pix_q[$];
  int acc_t[$];
  int exp_v[$];
  int exp_b[$];
  int exp_fd[$];

  int cyc = 0;
  int stray = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dout_valid4 === 1'b1)  obs4.push_back(obs_t'{int'(dout4), int'(frame_done4), cyc});
    if (dout_valid5 === 1'b1)  obs5.push_back(obs_t'{int'(dout5), int'(frame_done5), cyc});
    if (dout_valid26 === 1'b1) obs26.push_back(obs_t'{int'(dout26), int'(frame_done26), cyc});
    if (frame_done4 === 1'b1 && dout_valid4 !== 1'b1) stray++;
    if (frame_done5 === 1'b1 && dout_valid5 !== 1'b1) stray++;
    if (frame_done26 === 1'b1 && dout_valid26 !== 1'b1) stray++;
  end

  function automatic int relu_ref(input int x);
`ifdef MAXPOOL_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  // Floor 2x2 pooling of one frame held in pix_q starting at index base.
  function automatic void model_frame(input int base, input int cols, input int rows);
    for (int wr = 0; wr < rows / 2; wr++) begin
      for (int wc = 0; wc < cols / 2; wc++) begin
        int mx;
        mx = relu_ref(pix_q[base + (2 * wr) * cols + 2 * wc]);
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            int p;
            p = relu_ref(pix_q[base + (2 * wr + dy) * cols + 2 * wc + dx]);
            if (p > mx) mx = p;
          end
        end
        exp_v.push_back(mx);
        exp_b.push_back(base + (2 * wr + 1) * cols + 2 * wc + 1);
        exp_fd.push_back((wr == rows / 2 - 1 && wc == cols / 2 - 1) ? 1 : 0);
      end
    end
  endfunction

  task automatic clear_all();
    pix_q.delete();
    acc_t.delete();
    exp_v.delete();
    exp_b.delete();
    exp_fd.delete();
    obs4.delete();
    obs5.delete();
    obs26.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one pixel to the selected instance after `gap` idle cycles.
  task automatic send(input int sel, input int v, input int gap);
    idle(gap);
    case (sel)
      4:       begin din4  = v[8:0]; din_valid4  = 1'b1; end
      5:       begin din5  = v[8:0]; din_valid5  = 1'b1; end
      default: begin din26 = v[8:0]; din_valid26 = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    din_valid4  = 1'b0;
    din_valid5  = 1'b0;
    din_valid26 = 1'b0;
    acc_t.push_back(cyc);
    pix_q.push_back(v);
  endtask

  task automatic test_reset();
    idle(3);
    n_checks++;
    if (dout4 !== 9'sd0 || dout5 !== 9'sd0 || dout26 !== 9'sd0) begin
      n_fail++;
      $display("FAIL reset_dout: got %0d/%0d/%0d expected 0/0/0", dout4, dout5, dout26);
    end
    n_checks++;
    if ({dout_valid4, dout_valid5, dout_valid26} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_dout_valid: got %b expected 000", {dout_valid4, dout_valid5, dout_valid26});
    end
    n_checks++;
    if ({frame_done4, frame_done5, frame_done26} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_frame_done: got %b expected 000", {frame_done4, frame_done5, frame_done26});
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_spec_vector();
    int vec[16];
    int ev[4];
    int eb[4];
    vec = '{1, 5, 2, 3, 4, 0, 7, -1, -9, -8, -3, -2, -1, -6, -4, -5};
`ifdef MAXPOOL_RELU_EN
    ev = '{5, 7, 0, 0};
`else
    ev = '{5, 7, -1, -2};
`endif
    eb = '{5, 7, 13, 15};
    clear_all();
    for (int i = 0; i < 16; i++) send(4, vec[i], 0);
    idle(3);
    n_checks++;
    if (obs4.size() != 4) begin
      n_fail++;
      $display("FAIL vec_count: got %0d expected 4", obs4.size());
    end
    for (int i = 0; i < 4 && i < obs4.size(); i++) begin
      n_checks++;
      if (obs4[i].v != ev[i]) begin
        n_fail++;
        $display("FAIL vec_value[%0d]: got %0d expected %0d", i, obs4[i].v, ev[i]);
      end
      n_checks++;
      if (obs4[i].fd != ((i == 3) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL vec_frame_done[%0d]: got %0d expected %0d", i, obs4[i].fd, (i == 3) ? 1 : 0);
      end
      n_checks++;
      if (obs4[i].t != acc_t[eb[i]]) begin
        n_fail++;
        $display("FAIL vec_latency[%0d]: got cycle %0d expected %0d", i, obs4[i].t, acc_t[eb[i]]);
      end
    end
    n_checks++;
    if (int'(dout4) != ev[3]) begin
      n_fail++;
      $display("FAIL vec_dout_hold: got %0d expected %0d", dout4, ev[3]);
    end
  endtask

  task automatic test_gaps();
    int vec[16];
    int ev[4];
    int eb[4];
    vec = '{1, 5, 2, 3, 4, 0, 7, -1, -9, -8, -3, -2, -1, -6, -4, -5};
`ifdef MAXPOOL_RELU_EN
    ev = '{5, 7, 0, 0};
`else
    ev = '{5, 7, -1, -2};
`endif
    eb = '{5, 7, 13, 15};
    clear_all();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) send(4, vec[i], $urandom_range(0, 3));
    end
    idle(3);
    n_checks++;
    if (obs4.size() != 8) begin
      n_fail++;
      $display("FAIL gap_count: got %0d expected 8", obs4.size());
    end
    for (int i = 0; i < 8 && i < obs4.size(); i++) begin
      int b;
      b = 16 * (i / 4) + eb[i % 4];
      n_checks++;
      if (obs4[i].v != ev[i % 4]) begin
        n_fail++;
        $display("FAIL gap_value[%0d]: got %0d expected %0d", i, obs4[i].v, ev[i % 4]);
      end
      n_checks++;
      if (obs4[i].fd != ((i % 4 == 3) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL gap_frame_done[%0d]: got %0d expected %0d", i, obs4[i].fd, (i % 4 == 3) ? 1 : 0);
      end
      n_checks++;
      if (obs4[i].t != acc_t[b]) begin
        n_fail++;
        $display("FAIL gap_latency[%0d]: got cycle %0d expected %0d", i, obs4[i].t, acc_t[b]);
      end
    end
  endtask

  task automatic test_odd_dims();
    int ev[4];
    int eb[4];
    ev = '{6, 8, 16, 18};
    eb = '{6, 8, 16, 18};
    clear_all();
    for (int i = 0; i < 25; i++) send(5, i, 0);
    idle(3);
    n_checks++;
    if (obs5.size() != 4) begin
      n_fail++;
      $display("FAIL odd_count: got %0d expected 4", obs5.size());
    end
    for (int i = 0; i < 4 && i < obs5.size(); i++) begin
      n_checks++;
      if (obs5[i].v != ev[i]) begin
        n_fail++;
        $display("FAIL odd_value[%0d]: got %0d expected %0d", i, obs5[i].v, ev[i]);
      end
      n_checks++;
      if (obs5[i].fd != ((i == 3) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL odd_frame_done[%0d]: got %0d expected %0d", i, obs5[i].fd, (i == 3) ? 1 : 0);
      end
      n_checks++;
      if (obs5[i].t != acc_t[eb[i]]) begin
        n_fail++;
        $display("FAIL odd_latency[%0d]: got cycle %0d expected %0d", i, obs5[i].t, acc_t[eb[i]]);
      end
    end
    // Random signed 5x5 frame with gaps, checked against the window model.
    clear_all();
    for (int i = 0; i < 25; i++) send(5, int'($urandom_range(0, 511)) - 256, $urandom_range(0, 2));
    idle(3);
    model_frame(0, 5, 5);
    n_checks++;
    if (obs5.size() != exp_v.size()) begin
      n_fail++;
      $display("FAIL odd_rand_count: got %0d expected %0d", obs5.size(), exp_v.size());
    end
    for (int i = 0; i < exp_v.size() && i < obs5.size(); i++) begin
      n_checks++;
      if (obs5[i].v != exp_v[i] || obs5[i].fd != exp_fd[i] || obs5[i].t != acc_t[exp_b[i]]) begin
        n_fail++;
        $display("FAIL odd_rand[%0d]: got v=%0d fd=%0d t=%0d expected v=%0d fd=%0d t=%0d",
                 i, obs5[i].v, obs5[i].fd, obs5[i].t, exp_v[i], exp_fd[i], acc_t[exp_b[i]]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_all();
    for (int i = 0; i < 6; i++) send(4, int'($urandom_range(0, 511)) - 256, 0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dout4, dout_valid4, frame_done4} !== 11'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got dout=%0d vld=%b fd=%b expected 0/0/0", dout4, dout_valid4, frame_done4);
    end
    idle(3);
    n_checks++;
    if ({dout4, dout_valid4, frame_done4} !== 11'b0) begin
      n_fail++;
      $display("FAIL midreset_hold: got dout=%0d vld=%b fd=%b expected 0/0/0", dout4, dout_valid4, frame_done4);
    end
    clear_all();
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < 16; i++) send(4, int'($urandom_range(0, 511)) - 256, 0);
    idle(3);
    model_frame(0, 4, 4);
    n_checks++;
    if (obs4.size() != 4) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d expected 4", obs4.size());
    end
    for (int i = 0; i < exp_v.size() && i < obs4.size(); i++) begin
      n_checks++;
      if (obs4[i].v != exp_v[i] || obs4[i].fd != exp_fd[i] || obs4[i].t != acc_t[exp_b[i]]) begin
        n_fail++;
        $display("FAIL midreset_out[%0d]: got v=%0d fd=%0d t=%0d expected v=%0d fd=%0d t=%0d",
                 i, obs4[i].v, obs4[i].fd, obs4[i].t, exp_v[i], exp_fd[i], acc_t[exp_b[i]]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int fd_cnt;
    clear_all();
    for (int i = 0; i < 2 * 26 * 26; i++) send(26, int'($urandom_range(0, 511)) - 256, 0);
    idle(3);
    model_frame(0, 26, 26);
    model_frame(26 * 26, 26, 26);
    n_checks++;
    if (obs26.size() != 338) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected 338", obs26.size());
    end
    fd_cnt = 0;
    for (int i = 0; i < obs26.size(); i++) fd_cnt += obs26[i].fd;
    n_checks++;
    if (fd_cnt != 2) begin
      n_fail++;
      $display("FAIL b2b_frame_done_count: got %0d expected 2", fd_cnt);
    end
    for (int i = 0; i < exp_v.size() && i < obs26.size(); i++) begin
      n_checks++;
      if (obs26[i].v != exp_v[i] || obs26[i].fd != exp_fd[i] || obs26[i].t != acc_t[exp_b[i]]) begin
        n_fail++;
        $display("FAIL b2b_out[%0d]: got v=%0d fd=%0d t=%0d expected v=%0d fd=%0d t=%0d",
                 i, obs26[i].v, obs26[i].fd, obs26[i].t, exp_v[i], exp_fd[i], acc_t[exp_b[i]]);
      end
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL stray_frame_done: got %0d expected 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vector();
    test_gaps();
    test_odd_dims();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
